// File: rtl/reduce_frame_feeder.sv
// Input FIFO and frame sequencer that feeds exact FRAME_LEN-sample frames to reduce_sum.
// Optional zero-padding flush is enabled by defining FEEDER_PAD_EN.
module reduce_frame_feeder #(
    parameter int DATA_W      = 32,
    parameter int FRAME_LEN   = 512,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          res_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_cnt,
    output logic                          timeout_err
`ifdef FEEDER_PAD_EN
    ,
    input  logic                          flush
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              push, pop, pad_now, beat, empty;

`ifdef FEEDER_PAD_EN
    // Once flush is seen in STREAM, padding continues until the frame is complete.
    logic pad_q, pad_d;
    assign pad_now = (state_q == STREAM) && (pad_q || flush);
    always_comb begin
        pad_d = pad_now && (state_d == STREAM);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pad_q <= 1'b0;
        else      pad_q <= pad_d;
    end
`else
    assign pad_now = 1'b0;
`endif

    assign empty   = (level_q == '0);
    assign s_ready = (level_q != LVL_FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == STREAM) && !empty && !pad_now;
    assign beat    = pop || pad_now;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (!push && pop) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            sample_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            sample_cnt_q  <= sample_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d      = STREAM;
                    sample_cnt_d = '0;
                end
            end
            STREAM: begin
                if (beat) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        state_d   = WAIT_RES;
                        tmo_cnt_d = '0;
                    end
                end
            end
            WAIT_RES: begin
                // A result arriving on the final timeout cycle still counts as success.
                if (res_valid) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid_d = beat;
        m_data_d  = m_data_q;
        if (pop)          m_data_d = mem[rd_ptr_q];
        else if (pad_now) m_data_d = '0;
        busy = (state_q != IDLE);
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign fifo_level  = level_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reduce_frame_feeder.sv
// Bench for reduce_frame_feeder: queue-based reference of accepted samples, directed frame scenarios.
// Define FEEDER_PAD_EN to also exercise the zero-padding flush.
module tb_reduce_frame_feeder;

    localparam int FRAME_LEN   = 512;
    localparam int FIFO_DEPTH  = 16;
    localparam int TIMEOUT_CYC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        res_valid;
    logic        busy;
    logic [4:0]  fifo_level;
    logic [15:0] frame_cnt;
    logic        timeout_err;
`ifdef FEEDER_PAD_EN
    logic        flush;
`endif

    reduce_frame_feeder dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .res_valid(res_valid), .busy(busy),
        .fifo_level(fifo_level), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
`ifdef FEEDER_PAD_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          total_beats = 0;
    int          first_beat_cyc = -1;
    int          last_beat_cyc = 0;
    int          last_push_cyc = 0;
    longint      frame_sum = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every output beat must be the oldest not-yet-emitted accepted (or padded) sample.
    always @(negedge clk) begin
        if (rst === 1'b1 && m_valid === 1'b1) begin
            total_beats++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            frame_sum += m_data;
            if (exp_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
            else                   checkOutput("m_data_order", m_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input int gap);
        bit ready_now;
        bit accepted = 1'b0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 4000; i++) begin
            ready_now = s_ready;
            tick();
            if (ready_now) begin
                exp_q.push_back(d);
                last_push_cyc = cyc;
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("push_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target, input string tag);
        for (int i = 0; i < 5000 && total_beats < target; i++) tick();
        checkOutput(tag, total_beats, target);
    endtask

    task automatic pulse_res();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int first_push;
        int lastc;
        int k;
        rst       = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        res_valid = 1'b0;
`ifdef FEEDER_PAD_EN
        flush     = 1'b0;
`endif
        #12;
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        tick();
        rst = 1'b1;
        tick();

        // Frame of ones pushed back-to-back; result arrives 5 cycles after the last beat.
        first_beat_cyc = -1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            applyStimulus(32'd1, 0);
            if (i == 0) first_push = last_push_cyc;
        end
        wait_beats(FRAME_LEN, "t1_beats");
        checkOutput("t1_latency", first_beat_cyc - first_push, 2);
        checkOutput("t1_consecutive", last_beat_cyc - first_beat_cyc + 1, FRAME_LEN);
        checkOutput("t1_busy_wait", busy, 1);
        repeat (4) tick();
        pulse_res();
        checkOutput("t1_frame_cnt", frame_cnt, 1);
        checkOutput("t1_busy_idle", busy, 0);
        checkOutput("t1_timeout", timeout_err, 0);

        // Incrementing values with random gaps.
        first_beat_cyc = -1;
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(i, $urandom_range(0, 3));
        wait_beats(2 * FRAME_LEN, "t2_beats");
        checkOutput("t2_bubbles", (last_beat_cyc - first_beat_cyc + 1) > FRAME_LEN, 1);
        checkOutput("t2_model_drained", exp_q.size(), 0);
        pulse_res();
        checkOutput("t2_frame_cnt", frame_cnt, 2);

        // Fill the FIFO while waiting for a result.
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus($urandom, 0);
        wait_beats(3 * FRAME_LEN, "t3_beats");
        checkOutput("t3_busy_wait", busy, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(1000 + i, 0);
        checkOutput("t3_s_ready_full", s_ready, 0);
        checkOutput("t3_level_full", fifo_level, FIFO_DEPTH);
        s_valid = 1'b1;
        s_data  = 32'd2000;
        repeat (3) begin
            tick();
            checkOutput("t3_held_level", fifo_level, FIFO_DEPTH);
        end
        pulse_res();
        checkOutput("t3_frame_cnt", frame_cnt, 3);
        applyStimulus(32'd2000, 0);

        // Complete that frame and never answer it.
        for (int i = 0; i < FRAME_LEN - FIFO_DEPTH - 1; i++) applyStimulus($urandom, 0);
        wait_beats(4 * FRAME_LEN, "t4_beats");
        lastc = last_beat_cyc;
        for (int i = 0; i < 3000 && cyc < lastc + TIMEOUT_CYC - 1; i++) tick();
        checkOutput("t4_no_err_early", timeout_err, 0);
        checkOutput("t4_busy_early", busy, 1);
        tick();
        checkOutput("t4_err_cycle", cyc - lastc, TIMEOUT_CYC);
        checkOutput("t4_timeout_err", timeout_err, 1);
        checkOutput("t4_busy_idle", busy, 0);
        checkOutput("t4_frame_cnt", frame_cnt, 3);
        pulse_res();
        checkOutput("t4_res_ignored", frame_cnt, 3);
        checkOutput("t4_err_sticky", timeout_err, 1);

        // Reset in the middle of a frame.
        base = total_beats;
        k = 0;
        while (total_beats - base < 100 && k < 300) begin
            applyStimulus($urandom, 0);
            k++;
        end
        checkOutput("t5_beats_before_rst", total_beats - base, 100);
        rst     = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t5_m_valid", m_valid, 0);
        checkOutput("t5_m_data", m_data, 0);
        checkOutput("t5_level", fifo_level, 0);
        checkOutput("t5_s_ready", s_ready, 1);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_frame_cnt", frame_cnt, 0);
        checkOutput("t5_timeout", timeout_err, 0);
        tick();
        rst = 1'b1;
        tick();
        base = total_beats;
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(i + 7, 0);
        wait_beats(base + FRAME_LEN, "t5_frame_beats");
        tick();
        checkOutput("t5_busy_wait", busy, 1);
        pulse_res();
        checkOutput("t5_frame_after_rst", frame_cnt, 1);
        checkOutput("t5_busy_idle", busy, 0);

`ifdef FEEDER_PAD_EN
        // Ten threes, then flush pads the rest of the frame with zeros.
        base = total_beats;
        frame_sum = 0;
        for (int i = 0; i < 10; i++) applyStimulus(32'd3, 0);
        wait_beats(base + 10, "t6_data_beats");
        flush = 1'b1;
        for (int i = 0; i < FRAME_LEN - 10; i++) exp_q.push_back(32'd0);
        wait_beats(base + FRAME_LEN, "t6_frame_beats");
        flush = 1'b0;
        repeat (3) tick();
        checkOutput("t6_no_extra_beats", total_beats - base, FRAME_LEN);
        checkOutput("t6_sum", frame_sum, 30);
        checkOutput("t6_busy_wait", busy, 1);
        pulse_res();
        checkOutput("t6_frame_cnt", frame_cnt, 2);
`endif

        checkOutput("final_model_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
